// File: rtl/dwc_downconv_rd_ar_gen_if.sv
// AR channel plus read-data tracking push for the down-converter
// read-address generator.
interface dwc_downconv_rd_ar_gen_if #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32
) ();
    logic                  ARVALID;
    logic                  ARREADY;
    logic [ID_WIDTH-1:0]   ARID;
    logic [ADDR_WIDTH-1:0] ARADDR;
    logic [7:0]            ARLEN;
    logic [2:0]            ARSIZE;
    logic [1:0]            ARBURST;
    logic                  info_valid;
    logic                  info_ready;
    logic [2:0]            info_ratio_log2;
    logic                  info_last;

    modport master (
        output ARVALID, ARID, ARADDR, ARLEN, ARSIZE, ARBURST,
        output info_valid, info_ratio_log2, info_last,
        input  ARREADY, info_ready
    );

    modport slave (
        input  ARVALID, ARID, ARADDR, ARLEN, ARSIZE, ARBURST,
        input  info_valid, info_ratio_log2, info_last,
        output ARREADY, info_ready
    );
endinterface

// File: rtl/dwc_downconv_rd_ar_gen.sv
// Read-address generator of the AXI4 down-converter: splits one held
// master read command into slave-size ARs. Optional: DWC_DOWNCONV_RD_SEG_CNT_EN.
module dwc_downconv_rd_ar_gen #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  ACLK,
    input  logic                  sysReset,
    input  logic                  cmd_valid,
    input  logic [ID_WIDTH-1:0]   cmd_id,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic [2:0]            cmd_size,
    input  logic [1:0]            cmd_burst,
    input  logic [2:0]            slv_size,
    output logic                  cmd_get_next,
    output logic [15:0]           seg_count,
    dwc_downconv_rd_ar_gen_if.master ar
);

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        ISSUE,
        NEXT,
        DONE
    } state_t;

    // Everything needed to emit the remaining segments of a command.
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [15:0]           rem;
        logic [ADDR_WIDTH-1:0] run2_addr;
        logic [15:0]           run2_rem;
        logic                  fixed;
        logic [8:0]            fix_left;
        logic [7:0]            fix_len;
        logic [2:0]            size;
        logic [1:0]            burst;
        logic [2:0]            ratio;
    } plan_t;

    state_t state_q, state_d;
    plan_t  plan_q, calc, src, adv;

    logic                  down;
    logic [2:0]            shift;
    logic [ADDR_WIDTH-1:0] size_mask;
    logic [ADDR_WIDTH-1:0] a_aligned;
    logic [15:0]           total;
    logic [ADDR_WIDTH-1:0] cont;
    logic [ADDR_WIDTH-1:0] wbase;
    logic [ADDR_WIDTH-1:0] run1_bytes;
    logic [ADDR_WIDTH-1:0] run2_bytes;
    logic                  seg_more;
    logic [7:0]            seg_len;
    logic                  load;
    logic                  hs;

    // Derive the segment plan of the held command.
    always_comb begin
        down       = cmd_size > slv_size;
        shift      = down ? (cmd_size - slv_size) : 3'd0;
        size_mask  = (ADDR_WIDTH'(1) << cmd_size) - ADDR_WIDTH'(1);
        a_aligned  = cmd_addr & ~size_mask;
        total      = ({8'd0, cmd_len} + 16'd1) << shift;
        cont       = (ADDR_WIDTH'(cmd_len) + ADDR_WIDTH'(1)) << cmd_size;
        wbase      = cmd_addr & ~(cont - ADDR_WIDTH'(1));
        run1_bytes = wbase + cont - a_aligned;
        run2_bytes = a_aligned - wbase;
        calc       = '0;
        calc.ratio = shift;
        if (!down) begin
            calc.addr  = cmd_addr;
            calc.rem   = {8'd0, cmd_len} + 16'd1;
            calc.size  = cmd_size;
            calc.burst = cmd_burst;
        end else begin
            calc.addr  = a_aligned;
            calc.size  = slv_size;
            calc.burst = 2'b01;
            unique case (cmd_burst)
                2'b00: begin
                    calc.fixed    = 1'b1;
                    calc.fix_left = {1'b0, cmd_len} + 9'd1;
                    calc.fix_len  = 8'((9'd1 << shift) - 9'd1);
                end
                2'b10: begin
                    if (total <= 16'd16) begin
                        calc.rem   = total;
                        calc.burst = 2'b10;
                    end else begin
                        calc.rem       = 16'(run1_bytes >> slv_size);
                        calc.run2_addr = wbase;
                        calc.run2_rem  = 16'(run2_bytes >> slv_size);
                    end
                end
                default: begin
                    calc.rem = total;
                end
            endcase
        end
    end

    // Current segment: from fresh plan in CALC, else from the stored plan.
    always_comb begin
        src      = (state_q == CALC) ? calc : plan_q;
        seg_more = src.fixed ? (src.fix_left > 9'd1)
                             : ((src.rem > 16'd256) || (src.run2_rem != 16'd0));
        seg_len  = src.fixed ? src.fix_len
                 : ((src.rem > 16'd256) ? 8'd255 : 8'(src.rem - 16'd1));
    end

    // Plan after the current segment has been accepted.
    always_comb begin
        adv = plan_q;
        if (plan_q.fixed) begin
            adv.fix_left = plan_q.fix_left - 9'd1;
        end else if (plan_q.rem > 16'd256) begin
            adv.rem  = plan_q.rem - 16'd256;
            adv.addr = plan_q.addr + (ADDR_WIDTH'(256) << plan_q.size);
        end else begin
            adv.addr     = plan_q.run2_addr;
            adv.rem      = plan_q.run2_rem;
            adv.run2_rem = 16'd0;
        end
    end

    // State register.
    always_ff @(posedge ACLK or posedge sysReset) begin
        if (sysReset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake outputs.
    always_comb begin
        state_d       = state_q;
        ar.ARVALID    = 1'b0;
        ar.info_valid = 1'b0;
        cmd_get_next  = 1'b0;
        load          = 1'b0;
        hs            = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) state_d = CALC;
            end
            CALC, NEXT: begin
                if (ar.info_ready) begin
                    load    = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                ar.ARVALID    = 1'b1;
                hs            = ar.ARREADY;
                ar.info_valid = ar.ARREADY;
                if (ar.ARREADY) state_d = ar.info_last ? DONE : NEXT;
            end
            DONE: begin
                cmd_get_next = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Segment plan and registered AR fields.
    always_ff @(posedge ACLK or posedge sysReset) begin
        if (sysReset) begin
            plan_q             <= '0;
            ar.ARID            <= '0;
            ar.ARADDR          <= '0;
            ar.ARLEN           <= '0;
            ar.ARSIZE          <= '0;
            ar.ARBURST         <= '0;
            ar.info_ratio_log2 <= '0;
            ar.info_last       <= 1'b0;
        end else if (load) begin
            plan_q             <= src;
            ar.ARADDR          <= src.addr;
            ar.ARLEN           <= seg_len;
            ar.ARSIZE          <= src.size;
            ar.ARBURST         <= src.burst;
            ar.info_ratio_log2 <= src.ratio;
            ar.info_last       <= !seg_more;
            if (state_q == CALC) ar.ARID <= cmd_id;
        end else if (hs) begin
            plan_q <= adv;
        end
    end

`ifdef DWC_DOWNCONV_RD_SEG_CNT_EN
    logic [15:0] seg_cnt_q;

    // Saturating count of accepted ARs.
    always_ff @(posedge ACLK or posedge sysReset) begin
        if (sysReset) begin
            seg_cnt_q <= '0;
        end else if (hs && (seg_cnt_q != 16'hFFFF)) begin
            seg_cnt_q <= seg_cnt_q + 16'd1;
        end
    end

    assign seg_count = seg_cnt_q;
`else
    assign seg_count = '0;
`endif

endmodule

// File: tb/tb_dwc_downconv_rd_ar_gen.sv
// Directed bench for dwc_downconv_rd_ar_gen with an expected-AR queue
// filled per command and drained on each AR handshake.
module tb_dwc_downconv_rd_ar_gen;

    logic        ACLK = 1'b0;
    logic        sysReset;
    logic        cmd_valid;
    logic [3:0]  cmd_id;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [2:0]  cmd_size;
    logic [1:0]  cmd_burst;
    logic [2:0]  slv_size;
    logic        cmd_get_next;
    logic [15:0] seg_count;

    dwc_downconv_rd_ar_gen_if #(.ID_WIDTH(4), .ADDR_WIDTH(32)) ar_if ();

    dwc_downconv_rd_ar_gen #(.ID_WIDTH(4), .ADDR_WIDTH(32)) dut (
        .ACLK         (ACLK),
        .sysReset     (sysReset),
        .cmd_valid    (cmd_valid),
        .cmd_id       (cmd_id),
        .cmd_addr     (cmd_addr),
        .cmd_len      (cmd_len),
        .cmd_size     (cmd_size),
        .cmd_burst    (cmd_burst),
        .slv_size     (slv_size),
        .cmd_get_next (cmd_get_next),
        .seg_count    (seg_count),
        .ar           (ar_if)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [2:0]  ratio;
        logic        last;
        logic [3:0]  id;
    } exp_t;

    exp_t sb[$];
    int   passed   = 0;
    int   total    = 0;
    int   fails    = 0;
    int   hs_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [7:0] l,
                        input logic [2:0] s, input logic [1:0] b,
                        input logic [2:0] r, input logic lst,
                        input logic [3:0] id);
        exp_t e;
        e.addr = a; e.len = l; e.size = s; e.burst = b;
        e.ratio = r; e.last = lst; e.id = id;
        sb.push_back(e);
    endtask

    task automatic drive(input logic [3:0] id, input logic [31:0] a,
                         input logic [7:0] l, input logic [2:0] s,
                         input logic [1:0] b, input logic [2:0] slv);
        @(negedge ACLK);
        cmd_id    = id;
        cmd_addr  = a;
        cmd_len   = l;
        cmd_size  = s;
        cmd_burst = b;
        slv_size  = slv;
        cmd_valid = 1'b1;
    endtask

    task automatic run(input string nm, input int stall, input int ir_hold,
                       input bit rdy_rand, input bit spacing);
        int  cyc = 0;
        int  first_av = -1;
        int  last_hs = -1;
        int  gn = 0;
        int  gn_cyc = -1;
        int  stall_left = stall;
        bit  done = 1'b0;
        exp_t e;
        while (!done && cyc < 4000) begin
            @(negedge ACLK);
            cyc++;
            ar_if.info_ready = (cyc <= ir_hold) ? 1'b0 : 1'b1;
            if (ar_if.ARVALID && stall_left > 0) ar_if.ARREADY = 1'b0;
            else if (rdy_rand) ar_if.ARREADY = 1'($urandom_range(0, 1));
            else ar_if.ARREADY = 1'b1;
            #1;
            if (ar_if.ARVALID && first_av < 0) first_av = cyc;
            if (ar_if.ARVALID && !ar_if.ARREADY && stall_left > 0) begin
                stall_left--;
                chk({nm, "_stall_iv"}, 32'(ar_if.info_valid), 32'd0);
                if (sb.size() > 0) begin
                    chk({nm, "_stall_addr"}, ar_if.ARADDR, sb[0].addr);
                    chk({nm, "_stall_len"}, 32'(ar_if.ARLEN), 32'(sb[0].len));
                end
            end
            if (ar_if.ARVALID && ar_if.ARREADY) begin
                chk({nm, "_info_valid"}, 32'(ar_if.info_valid), 32'd1);
                if (sb.size() == 0) begin
                    chk({nm, "_extra_ar"}, 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    chk({nm, "_addr"}, ar_if.ARADDR, e.addr);
                    chk({nm, "_len"}, 32'(ar_if.ARLEN), 32'(e.len));
                    chk({nm, "_size"}, 32'(ar_if.ARSIZE), 32'(e.size));
                    chk({nm, "_burst"}, 32'(ar_if.ARBURST), 32'(e.burst));
                    chk({nm, "_ratio"}, 32'(ar_if.info_ratio_log2),
                        32'(e.ratio));
                    chk({nm, "_last"}, 32'(ar_if.info_last), 32'(e.last));
                    chk({nm, "_id"}, 32'(ar_if.ARID), 32'(e.id));
                end
                if (spacing && last_hs >= 0)
                    chk({nm, "_bubble"}, 32'(cyc - last_hs), 32'd2);
                last_hs = cyc;
                hs_total++;
            end
            if (cmd_get_next) begin
                gn++;
                gn_cyc = cyc;
                cmd_valid = 1'b0;
            end
            done = (gn > 0) && (sb.size() == 0);
        end
        chk({nm, "_timeout"}, 32'(done), 32'd1);
        chk({nm, "_first_av"}, 32'(first_av), 32'(2 + ir_hold));
        chk({nm, "_gn_lat"}, 32'(gn_cyc - last_hs), 32'd1);
        chk({nm, "_gn_cnt"}, 32'(gn), 32'd1);
        @(negedge ACLK);
        #1;
        chk({nm, "_gn_pulse"}, 32'(cmd_get_next), 32'd0);
    endtask

    initial begin
        int n;
        sysReset         = 1'b1;
        cmd_valid        = 1'b0;
        cmd_id           = '0;
        cmd_addr         = '0;
        cmd_len          = '0;
        cmd_size         = '0;
        cmd_burst        = '0;
        slv_size         = '0;
        ar_if.ARREADY    = 1'b0;
        ar_if.info_ready = 1'b1;
        repeat (3) @(negedge ACLK);
        chk("rst_arvalid", 32'(ar_if.ARVALID), 32'd0);
        chk("rst_info_valid", 32'(ar_if.info_valid), 32'd0);
        chk("rst_get_next", 32'(cmd_get_next), 32'd0);
        chk("rst_araddr", ar_if.ARADDR, 32'd0);
        chk("rst_arlen", 32'(ar_if.ARLEN), 32'd0);
        chk("rst_arid", 32'(ar_if.ARID), 32'd0);
        chk("rst_last", 32'(ar_if.info_last), 32'd0);
        chk("rst_seg_count", 32'(seg_count), 32'd0);
        sysReset = 1'b0;

        push(32'h1000, 8'd7, 3'd2, 2'd1, 3'd0, 1'b1, 4'd3);
        drive(4'd3, 32'h1000, 8'd7, 3'd2, 2'd1, 3'd2);
        run("pass", 0, 0, 1'b0, 1'b0);

        push(32'h100, 8'd7, 3'd2, 2'd1, 3'd1, 1'b1, 4'd5);
        drive(4'd5, 32'h104, 8'd3, 3'd3, 2'd1, 3'd2);
        run("incr_stall", 5, 0, 1'b0, 1'b0);

        for (int i = 0; i < 8; i++)
            push(32'(i) << 8, 8'd255, 3'd0, 2'd1, 3'd3, 1'(i == 7), 4'd1);
        drive(4'd1, 32'h0, 8'd255, 3'd3, 2'd1, 3'd0);
        run("incr8", 0, 0, 1'b0, 1'b1);

        push(32'h40, 8'd3, 3'd0, 2'd1, 3'd2, 1'b0, 4'd2);
        push(32'h40, 8'd3, 3'd0, 2'd1, 3'd2, 1'b1, 4'd2);
        drive(4'd2, 32'h40, 8'd1, 3'd2, 2'd0, 3'd0);
        run("fixed_irhold", 0, 4, 1'b0, 1'b0);

        push(32'h18, 8'd7, 3'd0, 2'd1, 3'd3, 1'b0, 4'd6);
        push(32'h00, 8'd23, 3'd0, 2'd1, 3'd3, 1'b1, 4'd6);
        drive(4'd6, 32'h18, 8'd3, 3'd3, 2'd2, 3'd0);
        run("wrap2", 0, 0, 1'b1, 1'b0);

        push(32'h28, 8'd3, 3'd2, 2'd2, 3'd1, 1'b1, 4'd7);
        drive(4'd7, 32'h28, 8'd1, 3'd3, 2'd2, 3'd2);
        run("wrap_small", 0, 0, 1'b0, 1'b0);

        push(32'h40, 8'd31, 3'd0, 2'd1, 3'd2, 1'b1, 4'd8);
        drive(4'd8, 32'h40, 8'd7, 3'd2, 2'd2, 3'd0);
        run("wrap_aligned", 0, 0, 1'b0, 1'b0);

        drive(4'd4, 32'h0, 8'd255, 3'd3, 2'd1, 3'd0);
        ar_if.ARREADY = 1'b0;
        n = 0;
        while (!ar_if.ARVALID && n < 10) begin
            @(negedge ACLK);
            n++;
        end
        chk("rst_mid_reach", 32'(ar_if.ARVALID), 32'd1);
        #1;
        sysReset = 1'b1;
        #1;
        chk("rst_mid_arvalid", 32'(ar_if.ARVALID), 32'd0);
        chk("rst_mid_iv", 32'(ar_if.info_valid), 32'd0);
        chk("rst_mid_gn", 32'(cmd_get_next), 32'd0);
        cmd_valid = 1'b0;
        hs_total  = 0;
        repeat (2) begin
            @(negedge ACLK);
            chk("rst_mid_gn_hold", 32'(cmd_get_next), 32'd0);
        end
        sysReset = 1'b0;
        @(negedge ACLK);
        chk("rst_mid_seg_count", 32'(seg_count), 32'd0);

        push(32'h2004, 8'd3, 3'd1, 2'd0, 3'd0, 1'b1, 4'd9);
        drive(4'd9, 32'h2004, 8'd3, 3'd1, 2'd0, 3'd2);
        run("pass_fixed", 0, 0, 1'b0, 1'b0);

`ifdef DWC_DOWNCONV_RD_SEG_CNT_EN
        chk("seg_count", 32'(seg_count), 32'(hs_total));
`else
        chk("seg_count", 32'(seg_count), 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
